// File: rtl/cp0_unit_pkg.sv
// CP0 shared definitions: register numbers, ExcCode values, Status/Cause
// field positions and reset constants.
package cp0_unit_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13
  } exc_code_e;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int CA_BD  = 31;
  localparam int CA_TI  = 30;
  localparam int CA_IV  = 23;
  localparam int CA_WP  = 22;

  localparam logic [31:0] STATUS_RST = 32'h1000_0000;

  // Only address-error exceptions carry a meaningful faulting address.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_unit_timer.sv
// CP0 timer: prescaler, Count, Compare and the sticky compare-match flag (TI).
module cp0_timer #(
  parameter int TIMER_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o,
  input  logic        ti_clear
);

  localparam logic [3:0] PRESC_LAST = 4'(TIMER_DIV - 1);

  logic [3:0]  presc_q, presc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        tick;

  always_comb begin
    tick      = (presc_q == PRESC_LAST);
    presc_d   = tick ? 4'd0 : presc_q + 4'd1;
    count_d   = tick ? count_q + 32'd1 : count_q;
    // A Count write restarts the prescale period as well as loading the value.
    if (count_we) begin
      presc_d = 4'd0;
      count_d = wdata;
    end
    compare_d = compare_we ? wdata : compare_q;
    ti_d      = ti_q | ((count_q == compare_q) && (compare_q != 32'd0));
    if (ti_clear) ti_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= 4'd0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_unit.sv
// CP0 system-control coprocessor: Status/Cause/EPC/BadVAddr, timer, masked
// interrupt request for the exception stage.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter int          HW_INT_NUM = 6,
  parameter int          TIMER_DIV  = 2,
  parameter logic [31:0] PRID_VAL   = 32'h004c0102,
  parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [4:0]            raddr_i,
  output logic [31:0]           rdata_o,
  input  logic [HW_INT_NUM-1:0] hw_int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_bd_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  eret_i,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  int_req_o
);

  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [31:0] count, compare;
  logic        ti;
  logic [5:0]  hw_pad;

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic        iv_q, iv_d;
  logic        wp_q, wp_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        int_req_q, int_req_d;

  assign wr_count   = we_i && (waddr_i == REG_COUNT);
  assign wr_compare = we_i && (waddr_i == REG_COMPARE);
  assign wr_status  = we_i && (waddr_i == REG_STATUS);
  assign wr_cause   = we_i && (waddr_i == REG_CAUSE);
  assign wr_epc     = we_i && (waddr_i == REG_EPC);

  // Unused hardware lines are zero-padded so their IP bits read 0.
  assign hw_pad = 6'(hw_int_i);

  cp0_timer #(.TIMER_DIV(TIMER_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (wdata_i),
    .count_o    (count),
    .compare_o  (compare),
    .ti_o       (ti),
    .ti_clear   (wr_compare)
  );

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    iv_d       = iv_q;
    wp_d       = wp_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    ip_hw_d    = {hw_pad[5] | ti, hw_pad[4:0]};
    int_req_d  = ie_q & ~exl_q & (|(im_q & {ip_hw_q, ip_sw_q}));

    if (wr_status) begin
      im_d  = wdata_i[15:8];
      exl_d = wdata_i[ST_EXL];
      ie_d  = wdata_i[ST_IE];
    end
    if (wr_cause) begin
      ip_sw_d = wdata_i[9:8];
      iv_d    = wdata_i[CA_IV];
      wp_d    = wdata_i[CA_WP];
    end
    if (wr_epc) epc_d = wdata_i;

    // ERET and exception updates are applied last so they override MTC0.
    if (eret_i) exl_d = 1'b0;
    if (exc_valid_i) begin
      exl_d     = 1'b1;
      exccode_d = exc_code_i;
      if (!exl_q) begin
        epc_d = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
        bd_d  = exc_bd_i;
      end
      if (is_addr_exc(exc_code_i)) badvaddr_d = exc_badvaddr_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      iv_q       <= 1'b0;
      wp_q       <= 1'b0;
      ip_sw_q    <= 2'd0;
      ip_hw_q    <= 6'd0;
      exccode_q  <= 5'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      int_req_q  <= 1'b0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      iv_q       <= iv_d;
      wp_q       <= wp_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      int_req_q  <= int_req_d;
    end
  end

  assign status_o  = STATUS_RST | {16'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_o   = {bd_q, ti, 6'd0, iv_q, wp_q, 6'd0, ip_hw_q, ip_sw_q,
                      1'b0, exccode_q, 2'b00};
  assign epc_o     = epc_q;
  assign int_req_o = int_req_q;

  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      REG_BADVADDR: rdata_o = badvaddr_q;
      REG_COUNT:    rdata_o = count;
      REG_COMPARE:  rdata_o = compare;
      REG_STATUS:   rdata_o = status_o;
      REG_CAUSE:    rdata_o = cause_o;
      REG_EPC:      rdata_o = epc_q;
      REG_PRID:     rdata_o = PRID_VAL;
      REG_CONFIG:   rdata_o = CONFIG_VAL;
      default:      rdata_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: reset read table, directed corner-case
// sequences and a randomized run against a word-level reference model.
module tb_cp0_unit;

  localparam int          HW_INT_NUM = 6;
  localparam int          TIMER_DIV  = 2;
  localparam logic [31:0] PRID_VAL   = 32'h004c0102;
  localparam logic [31:0] CONFIG_VAL = 32'h00008000;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  we_i = 1'b0;
  logic [4:0]            waddr_i = '0;
  logic [31:0]           wdata_i = '0;
  logic [4:0]            raddr_i = '0;
  logic [31:0]           rdata_o;
  logic [HW_INT_NUM-1:0] hw_int_i = '0;
  logic                  exc_valid_i = 1'b0;
  logic [4:0]            exc_code_i = '0;
  logic [31:0]           exc_pc_i = '0;
  logic                  exc_bd_i = 1'b0;
  logic [31:0]           exc_badvaddr_i = '0;
  logic                  eret_i = 1'b0;
  logic [31:0]           status_o, cause_o, epc_o;
  logic                  int_req_o;

  int checks = 0;
  int failures = 0;

  // Reference model state, kept as whole architectural words.
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_bad;
  logic        m_intreq;
  int          m_presc;

  cp0_unit #(
    .HW_INT_NUM(HW_INT_NUM), .TIMER_DIV(TIMER_DIV),
    .PRID_VAL(PRID_VAL), .CONFIG_VAL(CONFIG_VAL)
  ) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .hw_int_i(hw_int_i),
    .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
    .exc_bd_i(exc_bd_i), .exc_badvaddr_i(exc_badvaddr_i), .eret_i(eret_i),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .int_req_o(int_req_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_VAL;
      5'd16:   return CONFIG_VAL;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_count = 0; m_compare = 0; m_status = 32'h1000_0000; m_cause = 0;
    m_epc = 0; m_bad = 0; m_intreq = 1'b0; m_presc = 0;
  endtask

  task automatic check_all();
    check("status", status_o, m_status);
    check("cause", cause_o, m_cause);
    check("epc", epc_o, m_epc);
    check("int_req", {31'd0, int_req_o}, {31'd0, m_intreq});
    check("rdata", rdata_o, m_read(raddr_i));
  endtask

  task automatic idle();
    we_i = 1'b0; exc_valid_i = 1'b0; eret_i = 1'b0;
  endtask

  // Advance one clock: predict from pre-edge state and inputs, then compare.
  task automatic cycle();
    logic [31:0] cnt_n, cmp_n, st_n, ca_n, epc_n, bad_n;
    logic [5:0]  hwp;
    logic        ti, ti_n, ir_n;
    int          pr_n;
    bit          w9, w11, w12, w13, w14;
    w9  = we_i && waddr_i == 5'd9;
    w11 = we_i && waddr_i == 5'd11;
    w12 = we_i && waddr_i == 5'd12;
    w13 = we_i && waddr_i == 5'd13;
    w14 = we_i && waddr_i == 5'd14;
    if (w9) begin
      cnt_n = wdata_i; pr_n = 0;
    end else if (m_presc == TIMER_DIV - 1) begin
      cnt_n = m_count + 1; pr_n = 0;
    end else begin
      cnt_n = m_count; pr_n = m_presc + 1;
    end
    cmp_n = w11 ? wdata_i : m_compare;
    ti    = m_cause[30];
    ti_n  = w11 ? 1'b0 : (ti | (m_count == m_compare && m_compare != 0));
    ir_n  = m_status[0] && !m_status[1] && ((m_status[15:8] & m_cause[15:8]) != 0);
    st_n  = m_status;
    if (w12) st_n = (m_status & ~32'h0000_FF03) | (wdata_i & 32'h0000_FF03);
    ca_n = m_cause;
    if (w13) ca_n = (ca_n & ~32'h00C0_0300) | (wdata_i & 32'h00C0_0300);
    hwp = 6'(hw_int_i);
    for (int i = 0; i < 5; i++) ca_n[10+i] = hwp[i];
    ca_n[15] = ti | hwp[5];
    ca_n[30] = ti_n;
    epc_n = w14 ? wdata_i : m_epc;
    bad_n = m_bad;
    if (eret_i) st_n[1] = 1'b0;
    if (exc_valid_i) begin
      if (!m_status[1]) begin
        epc_n = exc_bd_i ? exc_pc_i - 4 : exc_pc_i;
        ca_n[31] = exc_bd_i;
      end
      st_n[1] = 1'b1;
      ca_n[6:2] = exc_code_i;
      if (exc_code_i == 5'd4 || exc_code_i == 5'd5) bad_n = exc_badvaddr_i;
    end
    @(posedge clk);
    #1;
    m_count = cnt_n; m_compare = cmp_n; m_status = st_n; m_cause = ca_n;
    m_epc = epc_n; m_bad = bad_n; m_intreq = ir_n; m_presc = pr_n;
    check_all();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
  endtask

  typedef struct {
    logic [4:0]  raddr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t tbl[10];
  logic [4:0] waddr_pool[9];
  logic [4:0] code_pool[7];

  initial begin
    int n;
    tbl[0] = '{5'd8,  32'h0};
    tbl[1] = '{5'd9,  32'h0};
    tbl[2] = '{5'd11, 32'h0};
    tbl[3] = '{5'd12, 32'h1000_0000};
    tbl[4] = '{5'd13, 32'h0};
    tbl[5] = '{5'd14, 32'h0};
    tbl[6] = '{5'd15, 32'h004c_0102};
    tbl[7] = '{5'd16, 32'h0000_8000};
    tbl[8] = '{5'd0,  32'h0};
    tbl[9] = '{5'd31, 32'h0};
    waddr_pool = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
    code_pool  = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12, 5'd13};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      raddr_i = tbl[i].raddr;
      #1;
      check($sformatf("reset_read_%0d", tbl[i].raddr), rdata_o, tbl[i].exp);
    end
    check("reset_int_req", {31'd0, int_req_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Timer compare match sets TI and then IP7.
    raddr_i = 5'd9;
    mtc0(5'd9, 32'd0);  cycle();
    mtc0(5'd11, 32'd5); cycle();
    idle();
    n = 0;
    while (!cause_o[30] && n < 40) begin cycle(); n++; end
    check("ti_set", {31'd0, cause_o[30]}, 32'd1);
    check("ti_count", rdata_o, 32'd5);
    cycle();
    check("ip7_set", {31'd0, cause_o[15]}, 32'd1);

    // Compare write during the match cycles keeps TI clear.
    mtc0(5'd9, 32'd0);  cycle();
    mtc0(5'd11, 32'd5); cycle();
    check("ti_cleared", {31'd0, cause_o[30]}, 32'd0);
    idle();
    n = 0;
    while (m_count != 5 && n < 40) begin cycle(); n++; end
    check("reach_5", rdata_o, 32'd5);
    mtc0(5'd11, 32'd5);
    n = 0;
    while (m_count == 5 && n < 40) begin cycle(); n++; end
    idle();
    cycle(); cycle();
    check("ti_clear_wins", {31'd0, cause_o[30]}, 32'd0);

    // Hardware interrupt to int_req with one cycle latency, masked by EXL.
    mtc0(5'd12, 32'h1000_0401); cycle();
    idle();
    hw_int_i = 6'b000001; cycle();
    check("ip2_set", {31'd0, cause_o[10]}, 32'd1);
    check("int_req_lag", {31'd0, int_req_o}, 32'd0);
    cycle();
    check("int_req_set", {31'd0, int_req_o}, 32'd1);
    exc_valid_i = 1'b1; exc_code_i = 5'd0; exc_pc_i = 32'h8000_0100; exc_bd_i = 1'b0;
    cycle();
    idle();
    cycle();
    check("int_req_exl", {31'd0, int_req_o}, 32'd0);
    hw_int_i = '0;

    // Address error in a delay slot, then a nested syscall.
    eret_i = 1'b1; cycle(); idle();
    exc_valid_i = 1'b1; exc_code_i = 5'd5; exc_bd_i = 1'b1;
    exc_pc_i = 32'h8000_1004; exc_badvaddr_i = 32'h0000_0003;
    raddr_i = 5'd8;
    cycle();
    check("exc_epc", epc_o, 32'h8000_1000);
    check("exc_bd", {31'd0, cause_o[31]}, 32'd1);
    check("exc_code", {27'd0, cause_o[6:2]}, 32'd5);
    check("exc_badvaddr", rdata_o, 32'd3);
    check("exc_exl", {31'd0, status_o[1]}, 32'd1);
    exc_code_i = 5'd8; exc_bd_i = 1'b0; exc_pc_i = 32'h8000_2000; exc_badvaddr_i = 32'hdead_beef;
    cycle();
    check("nested_epc", epc_o, 32'h8000_1000);
    check("nested_code", {27'd0, cause_o[6:2]}, 32'd8);
    check("nested_badvaddr", rdata_o, 32'd3);

    // Exception + ERET + MTC0 EPC together, then ERET alone.
    idle(); eret_i = 1'b1; cycle(); idle();
    exc_valid_i = 1'b1; eret_i = 1'b1; exc_code_i = 5'd12; exc_pc_i = 32'h8000_3000;
    mtc0(5'd14, 32'h0000_1234);
    cycle();
    check("simul_exl", {31'd0, status_o[1]}, 32'd1);
    check("simul_epc", epc_o, 32'h8000_3000);
    idle(); eret_i = 1'b1; cycle(); idle();
    check("eret_exl", {31'd0, status_o[1]}, 32'd0);

    // Count wrap with the prescaler restarted by the write.
    raddr_i = 5'd9;
    mtc0(5'd9, 32'hFFFF_FFFF); cycle(); idle();
    check("wrap_load", rdata_o, 32'hFFFF_FFFF);
    for (int k = 1; k < TIMER_DIV; k++) begin
      cycle();
      check("wrap_hold", rdata_o, 32'hFFFF_FFFF);
    end
    cycle();
    check("wrap_zero", rdata_o, 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      idle();
      if ($urandom_range(0, 9) < 3) begin
        waddr_i = waddr_pool[$urandom_range(0, 8)];
        wdata_i = (waddr_i == 5'd9 || waddr_i == 5'd11) ? 32'($urandom_range(0, 20)) : $urandom;
        we_i = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) begin
        exc_valid_i = 1'b1;
        exc_code_i = code_pool[$urandom_range(0, 6)];
        exc_pc_i = $urandom;
        exc_bd_i = 1'($urandom);
        exc_badvaddr_i = $urandom;
      end
      if ($urandom_range(0, 9) == 0) eret_i = 1'b1;
      if ($urandom_range(0, 3) == 0) hw_int_i = HW_INT_NUM'($urandom);
      raddr_i = 5'($urandom_range(0, 17));
      cycle();
    end

    // Asynchronous reset mid-operation.
    idle();
    #2;
    rst = 1'b1;
    #1;
    check("async_status", status_o, 32'h1000_0000);
    check("async_cause", cause_o, 32'd0);
    check("async_epc", epc_o, 32'd0);
    check("async_int_req", {31'd0, int_req_o}, 32'd0);
    raddr_i = 5'd9;
    #1;
    check("async_count", rdata_o, 32'd0);
    model_reset();
    hw_int_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
Parametrised CP0 system-control coprocessor. It is the successor to the fixed six-interrupt CP0 register file.
- Adds a configurable hardware interrupt count and a prescaled timer.
- Exceptions arrive as an encoded ExcCode rather than one-hot type words.
- Adds BadVAddr capture, Cause.TI, and software interrupts.
- Computes a masked interrupt request for the pipeline's exception stage.
Sits beside MEM/WB; receives committed exceptions from the exception arbiter and MTC0/MFC0 traffic from the pipeline.

Parameters:
HW_INT_NUM, 6, number of external hardware interrupt lines (1..6), mapped to Cause.IP[2+HW_INT_NUM-1:2]
TIMER_DIV, 2, Count increments once every TIMER_DIV clocks (1..16)
PRID_VAL, 32'h004c0102, read-only PRId value
CONFIG_VAL, 32'h00008000, read-only Config value

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
we_i  in  1  MTC0 write strobe
waddr_i  in  5  write register number
wdata_i  in  32  write data
raddr_i  in  5  MFC0 read register number
rdata_o  out  32  read data, combinational
hw_int_i  in  HW_INT_NUM  level-sensitive external interrupts
exc_valid_i  in  1  committed exception this cycle
exc_code_i  in  5  ExcCode (0 Int, 4 AdEL, 5 AdES, 8 Sys, 10 RI, 12 Ov, 13 Tr)
exc_pc_i  in  32  PC of faulting instruction
exc_bd_i  in  1  faulting instruction is in a delay slot
exc_badvaddr_i  in  32  faulting address, used for AdEL/AdES only
eret_i  in  1  committed ERET
status_o, cause_o, epc_o  out  32 each  live register values
int_req_o  out  1  interrupt pending and enabled (registered)

Behaviour:
- Registers: Count(9), Compare(11), Status(12), Cause(13), EPC(14), BadVAddr(8), PRId(15), Config(16).
- Reset values:
  - Count, Compare, Cause, EPC, BadVAddr = 0.
  - Status = 32'h1000_0000.
  - Prescaler = 0.
  - int_req_o = 0.
- Read: rdata_o = selected register. Unmapped address returns 0. Reads return the pre-edge value (no write bypass).
- Writable fields:
  - Count: all bits.
  - Compare: all bits.
  - Status: IM[15:8], EXL[1], IE[0]; other bits read back their reset value.
  - Cause: IP[9:8] (software interrupts), IV[23], WP[22].
  - EPC: all bits.
  - BadVAddr, PRId, Config: read-only.
- Timer:
  - The prescaler counts 0..TIMER_DIV-1; Count += 1 (wraps at 2^32) on the cycle the prescaler equals TIMER_DIV-1.
  - An MTC0 to Count loads wdata_i, clears the prescaler, and overrides the increment that cycle.
- Compare match:
  - When Count == Compare and Compare != 0 at an edge, Cause.TI[30] is set and stays sticky.
  - An MTC0 to Compare clears TI, and clearing wins over a simultaneous match.
- Hardware interrupt pending bits:
  - Cause.IP[2+i] <= hw_int_i[i] every cycle.
  - Cause.IP[7] <= hw_int_i[5] | TI when HW_INT_NUM = 6, else IP[7] <= TI.
  - Unused IP bits read 0.
- int_req_o <= Status.IE & ~Status.EXL & |(Status.IM & Cause.IP), computed from pre-edge values, i.e. one-cycle latency.
- Exception (exc_valid_i = 1):
  - If EXL = 0: EPC <= exc_bd_i ? exc_pc_i-4 : exc_pc_i, and Cause.BD[31] <= exc_bd_i.
  - If EXL = 1: EPC and BD are unchanged (nested exception).
  - Always: EXL <= 1 and Cause.ExcCode[6:2] <= exc_code_i.
  - BadVAddr <= exc_badvaddr_i only when the code is 4 or 5.
- ERET: EXL <= 0.
- Simultaneous events:
  - exc_valid_i and eret_i together: the exception wins and EXL stays 1.
  - An MTC0 to Status/Cause/EPC in the same cycle as an exception or ERET: the exception/ERET field updates win. Non-overlapping fields of the MTC0 still apply.
  - Count/Compare writes are never suppressed.
- Reset asserted mid-operation returns every register to its reset value asynchronously; the prescaler restarts at 0 after release.

Decomposition:
- Shared defines header cp0_defs:
  - CP0 register numbers.
  - ExcCode constants.
  - Status/Cause bit positions (EXL, IE, BD, TI, IP/IM ranges).
  - Reset constants.
- Sub-module cp0_timer owns the prescaler, Count, Compare, and TI sticky logic. Ports: clk, rst, count/compare write strobes, wdata, count_o, compare_o, ti_o, ti_clear.

Test Plan:
- Reset, then read all eight addresses -> Status 32'h10000000, PRId 32'h004c0102, Config 32'h00008000, the rest 0.
- TIMER_DIV=2, write Compare=5 -> TI and IP7 set once Count reaches 5 (~10 clocks); write Compare=5 again in the match cycle -> TI stays 0.
- Status=32'h10000401 (IE=1, IM2=1), assert hw_int_i[0] -> Cause.IP2 = 1 the next cycle, int_req_o = 1 one cycle later; set EXL via exception -> int_req_o drops.
- Exception code 5, bd=1, pc=32'h80001004, badvaddr=32'h00000003 -> EPC = 32'h80001000, BD = 1, ExcCode = 5, BadVAddr = 3, EXL = 1; a second exception code 8 -> EPC unchanged, ExcCode = 8.
- exc_valid_i and eret_i in the same cycle with MTC0 EPC=32'h1234 -> EXL = 1, EPC = exception value; next cycle an ERET alone clears EXL.
- Write Count=32'hFFFFFFFF -> wraps to 0 after TIMER_DIV clocks, prescaler restarted by the write.
